// File: rtl/serial_adder_pkg.sv
// ----------------------------------------------------------------------------
// serial_adder_pkg
//
// Purpose:
//   Definitions shared by the bit-serial adder controller and its datapath.
//   - FSM state encoding. Plain 2-bit localparam constants are used so the
//     encoding is stable and can be matched by older tooling.
//   - A helper that sizes the bit counter.
//
// Contents:
//   ST_IDLE / ST_RUN / ST_DONE : 2-bit state codes. Code 2'd3 is unused.
//   cnt_width(width)           : max(1, $clog2(width))
// ----------------------------------------------------------------------------
package serial_adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // The counter must index bit positions 0..width-1. A 1-bit adder still
  // needs a real counter signal, so the width never drops below one bit.
  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_full_adder_cell.sv
// ----------------------------------------------------------------------------
// half_adder / full_adder_cell
//
// Purpose:
//   The single-bit arithmetic datapath that the serial controller sequences.
//   full_adder_cell is built from two half adders. The carry is the OR of the
//   two half-adder carries. The carries can never both be high, so this OR is
//   the usual majority function.
//
// half_adder ports:
//   a, b      in   operand bits
//   s         out  a ^ b
//   c         out  a & b
//
// full_adder_cell ports:
//   a, b      in   operand bits
//   cin       in   carry in
//   s         out  a ^ b ^ cin
//   cout      out  majority(a, b, cin)
// ----------------------------------------------------------------------------
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule


module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic s0;
  logic c0;
  logic c1;

  // First stage adds the operand bits.
  half_adder u_ha0 (
    .a (a),
    .b (b),
    .s (s0),
    .c (c0)
  );

  // Second stage folds in the incoming carry.
  half_adder u_ha1 (
    .a (s0),
    .b (cin),
    .s (s),
    .c (c1)
  );

  assign cout = c0 | c1;

endmodule

// File: rtl/serial_adder_ctrl.sv
// ----------------------------------------------------------------------------
// serial_adder_ctrl
//
// Purpose:
//   Bit-serial WIDTH-bit adder. Operands and a carry-in are accepted through
//   a valid/ready handshake. The sum is then built LSB-first, one
//   full_adder_cell evaluation per cycle, over WIDTH cycles. The result and
//   the carry-out are held behind a second valid/ready handshake until
//   downstream takes them.
//
// Parameters:
//   WIDTH      operand/result width, WIDTH >= 1
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   in_valid   in   operands valid
//   in_ready   out  high only in IDLE
//   a, b       in   operands, sampled on the accept edge
//   cin        in   carry-in, sampled on the accept edge
//   busy       out  high while in RUN
//   out_valid  out  high only in DONE
//   out_ready  in   downstream accepts the result
//   sum        out  (a + b + cin) mod 2^WIDTH
//   cout       out  carry register (bit WIDTH of a + b + cin once in DONE)
// ----------------------------------------------------------------------------
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  logic [1:0]       state_reg;
  logic [1:0]       state_next;
  logic [WIDTH-1:0] a_sr_reg;
  logic [WIDTH-1:0] b_sr_reg;
  logic [WIDTH-1:0] sum_reg;
  logic [WIDTH-1:0] sum_next;
  logic             carry_reg;
  logic [CW-1:0]    cnt_reg;

  logic             fa_s;
  logic             fa_c;

  logic             accept;
  logic             last_bit;

  // --------------------------------------------------------------------------
  // Single-bit datapath: always looks at the current LSBs and carry.
  // --------------------------------------------------------------------------
  full_adder_cell u_fa (
    .a    (a_sr_reg[0]),
    .b    (b_sr_reg[0]),
    .cin  (carry_reg),
    .s    (fa_s),
    .cout (fa_c)
  );

  // --------------------------------------------------------------------------
  // Sum shifter. The new bit enters at the MSB and older bits move toward the
  // LSB, so after WIDTH shifts bit 0 holds the first computed sum bit. The
  // shifter is written per bit so that WIDTH=1 has no empty slice.
  // --------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sum_shift
      if (gi == WIDTH - 1) begin : g_msb
        assign sum_next[gi] = fa_s;
      end else begin : g_lower
        assign sum_next[gi] = sum_reg[gi + 1];
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // FSM next state
  // --------------------------------------------------------------------------
  assign accept   = (state_reg == ST_IDLE) && in_valid;
  assign last_bit = (cnt_reg == CNT_LAST);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (in_valid) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (last_bit) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        // in_valid is deliberately ignored here. A new operation can only
        // be accepted once the controller is back in IDLE.
        if (out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        // The unused code 2'd3 recovers to IDLE.
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr_reg  <= '0;
      b_sr_reg  <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
    end else if (accept) begin
      a_sr_reg  <= a;
      b_sr_reg  <= b;
      sum_reg   <= '0;
      carry_reg <= cin;
      cnt_reg   <= '0;
    end else if (state_reg == ST_RUN) begin
      a_sr_reg  <= a_sr_reg >> 1;
      b_sr_reg  <= b_sr_reg >> 1;
      sum_reg   <= sum_next;
      carry_reg <= fa_c;
      cnt_reg   <= cnt_reg + CNT_ONE;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs decode from registered state only. There is no combinational path
  // from in_valid or out_ready to in_ready or out_valid.
  // --------------------------------------------------------------------------
  assign in_ready  = (state_reg == ST_IDLE);
  assign busy      = (state_reg == ST_RUN);
  assign out_valid = (state_reg == ST_DONE);
  assign sum       = sum_reg;
  assign cout      = carry_reg;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// ----------------------------------------------------------------------------
// tb_serial_adder_ctrl
//
// Purpose:
//   Self-checking bench for serial_adder_ctrl. It uses an 8-bit instance and
//   a 1-bit instance. Expected {cout, sum} values are pushed to a scoreboard
//   queue on each accept edge. They are popped and compared when the DUT
//   presents its result.
// ----------------------------------------------------------------------------
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // 8-bit instance
  logic       in_valid8, in_ready8, busy8, out_valid8, out_ready8, cin8, cout8;
  logic [7:0] a8, b8, sum8;

  // 1-bit instance
  logic       in_valid1, in_ready1, busy1, out_valid1, out_ready1, cin1, cout1;
  logic [0:0] a1, b1, sum1;

  int n_checks = 0;
  int n_pass   = 0;

  logic [8:0] q8[$];
  logic [1:0] q1[$];

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .a         (a8),
    .b         (b8),
    .cin       (cin8),
    .busy      (busy8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .sum       (sum8),
    .cout      (cout8)
  );

  serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .a         (a1),
    .b         (b1),
    .cin       (cin1),
    .busy      (busy1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .sum       (sum1),
    .cout      (cout1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Entered at a negedge. It drives one operation on the 8-bit DUT,
  // optionally holds DONE for bp cycles with in_valid asserted, completes
  // the output handshake, and returns at a negedge with the DUT in IDLE.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c, input int bp);
    logic [8:0] e;
    logic [7:0] hold_sum;
    logic       hold_cout;
    int         lat;
    int         bcnt;
    a8 = a; b8 = b; cin8 = c; in_valid8 = 1'b1;
    check("in_ready8_before_accept", in_ready8, 1);
    @(posedge clk);
    q8.push_back({1'b0, a} + {1'b0, b} + 9'(c));
    @(negedge clk);
    // Operands may change freely after the accept edge.
    in_valid8 = 1'b0; a8 = ~a; b8 = ~b; cin8 = ~c;
    lat = 0; bcnt = 0;
    while (!out_valid8 && lat < 40) begin
      if (busy8) bcnt++;
      @(negedge clk);
      lat++;
    end
    check("latency8", lat, 8);
    check("busy_cycles8", bcnt, 8);
    check("in_ready8_in_done", in_ready8, 0);
    hold_sum = sum8; hold_cout = cout8;
    for (int i = 0; i < bp; i++) begin
      in_valid8 = 1'b1; a8 = 8'h3C; b8 = 8'h77; cin8 = 1'b1;
      @(negedge clk);
      check("bp_sum_stable", sum8, hold_sum);
      check("bp_cout_stable", cout8, hold_cout);
      check("bp_out_valid", out_valid8, 1);
      check("bp_in_ready", in_ready8, 0);
    end
    if (q8.size() == 0) begin
      check("sb8_nonempty", 0, 1);
    end else begin
      e = q8.pop_front();
      $display("op8 a=%02h b=%02h cin=%0d -> sum=%02h cout=%0d (exp %02h %0d)",
               a, b, c, sum8, cout8, e[7:0], e[8]);
      check("sum8", sum8, e[7:0]);
      check("cout8", cout8, e[8]);
    end
    out_ready8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready8 = 1'b0;
    // If in_valid was held through the handshake edge, it must not have
    // been accepted there.
    check("post_hs_out_valid8", out_valid8, 0);
    check("post_hs_in_ready8", in_ready8, 1);
    check("post_hs_busy8", busy8, 0);
    in_valid8 = 1'b0;
  endtask

  task automatic op1(input logic a, input logic b, input logic c);
    logic [1:0] e;
    int         lat;
    int         bcnt;
    a1 = a; b1 = b; cin1 = c; in_valid1 = 1'b1;
    @(posedge clk);
    q1.push_back(2'(a) + 2'(b) + 2'(c));
    @(negedge clk);
    in_valid1 = 1'b0; a1 = ~a; b1 = ~b; cin1 = ~c;
    lat = 0; bcnt = 0;
    while (!out_valid1 && lat < 10) begin
      if (busy1) bcnt++;
      @(negedge clk);
      lat++;
    end
    check("latency1", lat, 1);
    check("busy_cycles1", bcnt, 1);
    if (q1.size() == 0) begin
      check("sb1_nonempty", 0, 1);
    end else begin
      e = q1.pop_front();
      $display("op1 a=%0d b=%0d cin=%0d -> {cout,sum}=%0d (exp %0d)",
               a, b, c, {cout1, sum1}, e);
      check("sum_cout1", {cout1, sum1}, e);
    end
    out_ready1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready1 = 1'b0;
    check("post_hs_in_ready1", in_ready1, 1);
  endtask

  initial begin
    int ov_seen;
    rst = 1'b1;
    in_valid8 = 0; out_ready8 = 0; a8 = 0; b8 = 0; cin8 = 0;
    in_valid1 = 0; out_ready1 = 0; a1 = 0; b1 = 0; cin1 = 0;
    repeat (3) @(negedge clk);
    check("rst_in_ready8", in_ready8, 1);
    check("rst_busy8", busy8, 0);
    check("rst_out_valid8", out_valid8, 0);
    check("rst_sum8", sum8, 0);
    check("rst_cout8", cout8, 0);
    check("rst_in_ready1", in_ready1, 1);
    check("rst_out_valid1", out_valid1, 0);
    rst = 1'b0;
    @(negedge clk);

    op8(8'h00, 8'h00, 1'b0, 0);
    op8(8'hFF, 8'h01, 1'b0, 0);
    op8(8'hA5, 8'h5A, 1'b1, 0);
    op8(8'h12, 8'h34, 1'b0, 0);   // accepted in the cycle after the handshake
    op8(8'hC3, 8'h3C, 1'b1, 5);   // backpressure with in_valid held
    op8(8'h0F, 8'hF1, 1'b1, 0);   // accepted right after backpressure release
    for (int i = 0; i < 4; i++) begin
      op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 0);
    end

    // Reset during the 3rd RUN cycle. The partial result is discarded.
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b0; in_valid8 = 1'b1;
    @(posedge clk);               // accept
    @(negedge clk); in_valid8 = 1'b0;   // RUN cycle 1
    @(negedge clk);                     // RUN cycle 2
    @(negedge clk); rst = 1'b1;         // RUN cycle 3
    @(negedge clk);
    check("abort_in_ready8", in_ready8, 1);
    check("abort_busy8", busy8, 0);
    check("abort_out_valid8", out_valid8, 0);
    check("abort_sum8", sum8, 0);
    check("abort_cout8", cout8, 0);
    rst = 1'b0;
    ov_seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid8) ov_seen++;
    end
    check("abort_no_out_valid8", ov_seen, 0);

    // in_valid coincident with rst: nothing is accepted.
    rst = 1'b1; in_valid8 = 1'b1; a8 = 8'h11; b8 = 8'h22;
    @(negedge clk);
    check("rst_vs_valid_busy8", busy8, 0);
    check("rst_vs_valid_in_ready8", in_ready8, 1);
    rst = 1'b0; in_valid8 = 1'b0;
    @(negedge clk);
    check("rst_vs_valid_idle8", busy8, 0);

    // Normal operation after the aborted operation.
    op8(8'h80, 8'h80, 1'b1, 0);

    // WIDTH=1: all input combinations.
    for (int v = 0; v < 8; v++) begin
      op1(v[2], v[1], v[0]);
    end

    check("sb8_drained", q8.size(), 0);
    check("sb1_drained", q1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
